// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM state encoding
// and the datapath width.
package alu_pkg;

    localparam int DW = 16;

    typedef enum logic [1:0] {
        OP_SUM = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o
);

    logic found;

    // Scan priority order starting at ptr_i; first hit wins.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == ((int'(ptr_i) + k) % NREQ)) && req_i[j]) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    gnt_id_o = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one external 16-bit ALU between NREQ requesters: round-robin accept,
// registered operands drive the ALU, registered result held on a tagged response.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int MUL_CYCLES = 2,
    parameter int IDW        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [DW*NREQ-1:0] req_a,
    input  logic [DW*NREQ-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [DW-1:0]     resp_data,
    output logic              resp_err,
    output logic [DW-1:0]     alu_data1,
    output logic [DW-1:0]     alu_data2,
    output logic [1:0]        alu_sel,
    input  logic [DW-1:0]     alu_result
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [1:0]      sel_op;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    // Only the granted slice is selected, so X on idle requesters never reaches state.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[DW*i +: DW];
                sel_b  = req_b[DW*i +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        resp_id_d   = resp_id_q;
        req_ready   = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = rst_n ? gnt : '0;
                if (|(req_valid & req_ready)) begin
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = gnt_id;
                    cnt_d   = (sel_op == OP_MUL) ? 2'(MUL_CYCLES - 1) : 2'd0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    resp_data_d = (op_q == OP_RSV) ? '0 : alu_result;
                    resp_err_d  = (op_q == OP_RSV);
                    resp_id_d   = id_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign alu_data1  = a_q;
    assign alu_data2  = b_q;
    assign alu_sel    = op_q;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: directed requests push expected responses,
// a negedge monitor checks accepts, latency, hold-under-backpressure and results.
module tb_alu_sched;

    localparam int NREQ = 2;
    localparam int MULC = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [15:0]       resp_data;
    logic              resp_err;
    logic [15:0]       alu_data1;
    logic [15:0]       alu_data2;
    logic [1:0]        alu_sel;
    logic [15:0]       alu_result;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
        int          lat;
        int          acceptCyc;
    } exp_t;

    exp_t expQ[$];
    exp_t inflight[$];
    int   acceptCycQ[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acceptCount = 0;
    int lastAcceptCyc = 0;
    int lastHsCyc = 0;
    int riseCyc = 0;
    logic prevValid = 1'b0;
    logic [IDW-1:0] heldId;
    logic [15:0]    heldData;
    logic           heldErr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model; the reserved encoding returns junk the DUT must mask.
    always_comb begin
        case (alu_sel)
            2'b00:   alu_result = alu_data1 + alu_data2;
            2'b01:   alu_result = alu_data1 - alu_data2;
            2'b10:   alu_result = alu_data1 * alu_data2;
            default: alu_result = 16'hBEEF;
        endcase
    end

    alu_sched #(
        .NREQ       (NREQ),
        .MUL_CYCLES (MULC),
        .IDW        (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_sel    (alu_sel),
        .alu_result (alu_result)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 0);
        checkOutput({tag, "_resp_id"}, 32'(resp_id), 0);
        checkOutput({tag, "_resp_data"}, 32'(resp_data), 0);
        checkOutput({tag, "_resp_err"}, 32'(resp_err), 0);
        checkOutput({tag, "_alu_data1"}, 32'(alu_data1), 0);
        checkOutput({tag, "_alu_data2"}, 32'(alu_data2), 0);
        checkOutput({tag, "_alu_sel"}, 32'(alu_sel), 0);
    endtask

    // Monitor: accepts pop the expected queue, responses pop the in-flight queue.
    always @(negedge clk) begin
        int aid;
        exp_t e;
        if (!rst_n) begin
            inflight.delete();
            prevValid = 1'b0;
        end else begin
            if (|(req_valid & req_ready)) begin
                aid = 0;
                for (int i = 0; i < NREQ; i++) if (req_valid[i] & req_ready[i]) aid = i;
                checkOutput("ready_onehot", $countones(req_ready), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_accept", 32'(aid), 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("accept_id", 32'(aid), 32'(e.id));
                    e.acceptCyc = cyc;
                    inflight.push_back(e);
                end
                acceptCount++;
                lastAcceptCyc = cyc;
                acceptCycQ.push_back(cyc);
            end
            if (resp_valid) begin
                checkOutput("ready_in_resp", 32'(req_ready), 0);
                if (!prevValid) begin
                    riseCyc = cyc;
                end else begin
                    checkOutput("hold_id", 32'(resp_id), 32'(heldId));
                    checkOutput("hold_data", 32'(resp_data), 32'(heldData));
                    checkOutput("hold_err", 32'(resp_err), 32'(heldErr));
                end
                heldId   = resp_id;
                heldData = resp_data;
                heldErr  = resp_err;
                if (resp_ready) begin
                    if (inflight.size() == 0) begin
                        checkOutput("unexpected_resp", 32'(resp_data), 32'hFFFF_FFFF);
                    end else begin
                        e = inflight.pop_front();
                        checkOutput("resp_id", 32'(resp_id), 32'(e.id));
                        checkOutput("resp_data", 32'(resp_data), 32'(e.data));
                        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
                        checkOutput("latency", 32'(riseCyc - e.acceptCyc), 32'(e.lat));
                    end
                    lastHsCyc = cyc;
                    prevValid = 1'b0;
                end else begin
                    prevValid = 1'b1;
                end
            end else begin
                prevValid = 1'b0;
            end
        end
    end

    task automatic setReq(input int id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op[2*id +: 2]   = op;
        req_a[16*id +: 16]  = a;
        req_b[16*id +: 16]  = b;
        req_valid[id]       = 1'b1;
    endtask

    task automatic clrReq(input int id);
        req_valid[id]       = 1'b0;
        req_op[2*id +: 2]   = 'x;
        req_a[16*id +: 16]  = 'x;
        req_b[16*id +: 16]  = 'x;
    endtask

    task automatic pushExp(input int id, input logic [15:0] data, input logic err, input int lat);
        exp_t e;
        e.id = id; e.data = data; e.err = err; e.lat = lat; e.acceptCyc = 0;
        expQ.push_back(e);
    endtask

    task automatic waitAccepts(input int target);
        int n = 0;
        while (acceptCount < target && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("accept_timeout", 32'(acceptCount >= target), 1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || inflight.size() != 0) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("drain_timeout", 32'(n < 100), 1);
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] expData, input logic expErr, input int expLat);
        int target;
        target = acceptCount + 1;
        pushExp(id, expData, expErr, expLat);
        setReq(id, op, a, b);
        waitAccepts(target);
        @(posedge clk); #1;
        clrReq(id);
    endtask

    initial begin
        int target;
        int relCyc;
        int n0;
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        req_valid  = '0;
        req_op     = 'x;
        req_a      = 'x;
        req_b      = 'x;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkAllZero("post_reset_idle");

        $display("[TB] single SUM / reserved / wrap / MUL vectors");
        applyStimulus(0, 2'b00, 16'h0005, 16'h0003, 16'h0008, 1'b0, 2);
        applyStimulus(1, 2'b11, 16'h1234, 16'h0001, 16'h0000, 1'b1, 2);
        applyStimulus(1, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 2);
        applyStimulus(0, 2'b10, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1 + MULC);
        applyStimulus(1, 2'b10, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1 + MULC);
        waitDrain();

        $display("[TB] round-robin with both requesters valid");
        n0 = acceptCycQ.size();
        target = acceptCount;
        pushExp(0, 16'h8000, 1'b0, 2);
        pushExp(1, 16'h000D, 1'b0, 2);
        pushExp(0, 16'h0001, 1'b0, 2);
        pushExp(1, 16'hF000, 1'b0, 2);
        setReq(0, 2'b00, 16'h7FFF, 16'h0001);
        setReq(1, 2'b01, 16'h0010, 16'h0003);
        waitAccepts(target + 1);
        @(posedge clk); #1;
        setReq(0, 2'b00, 16'hFFFF, 16'h0002);
        waitAccepts(target + 2);
        @(posedge clk); #1;
        setReq(1, 2'b01, 16'h1000, 16'h2000);
        waitAccepts(target + 3);
        @(posedge clk); #1;
        clrReq(0);
        waitAccepts(target + 4);
        @(posedge clk); #1;
        clrReq(1);
        for (int k = 1; k < 4; k++) begin
            if (acceptCycQ.size() > n0 + k)
                checkOutput("rr_spacing", 32'(acceptCycQ[n0+k] - acceptCycQ[n0+k-1]), 3);
        end
        waitDrain();

        $display("[TB] back-pressure with a second request pending");
        target = acceptCount;
        resp_ready = 1'b0;
        pushExp(0, 16'h0055, 1'b0, 2);
        pushExp(1, 16'h0004, 1'b0, 2);
        setReq(0, 2'b01, 16'h00AA, 16'h0055);
        setReq(1, 2'b00, 16'h0002, 16'h0002);
        waitAccepts(target + 1);
        @(posedge clk); #1;
        clrReq(0);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("bp_resp_valid", 32'(resp_valid), 1);
        checkOutput("bp_no_accept", 32'(acceptCount), 32'(target + 1));
        resp_ready = 1'b1;
        waitAccepts(target + 2);
        checkOutput("bp_next_accept", 32'(lastAcceptCyc), 32'(lastHsCyc + 1));
        @(posedge clk); #1;
        clrReq(1);
        waitDrain();

        $display("[TB] reset during MUL execution");
        target = acceptCount;
        pushExp(0, 16'h000C, 1'b0, 1 + MULC);
        setReq(0, 2'b10, 16'h0003, 16'h0004);
        waitAccepts(target + 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("mid_mul_reset");
        repeat (2) @(posedge clk);
        #1;
        pushExp(0, 16'h000C, 1'b0, 1 + MULC);
        rst_n  = 1'b1;
        relCyc = cyc;
        waitAccepts(target + 2);
        checkOutput("reaccept_cycle", 32'(lastAcceptCyc), 32'(relCyc));
        @(posedge clk); #1;
        clrReq(0);
        waitDrain();
        checkOutput("final_queue_empty", 32'(expQ.size() + inflight.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Sequences and shares the single 16-bit combinational ALU between NREQ requesters (fetch/address unit, execute unit, ...).
- Each requester issues one operation (op, a, b) with a valid/ready handshake.
- The block grants round-robin, drives the ALU ports from registered operands, and holds the registered result on a shared response channel tagged with the requester id.
- It sits between the CPU control units and the ALU instance; the ALU itself stays outside this block.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- MUL_CYCLES, 2, EXEC cycles spent on MUL (multicycle path budget); legal range 1..4. SUM and SUB always take 1 cycle.
- IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_op  in  2*NREQ  op per requester, slice i = [2i+1:2i]; 00 SUM, 01 SUB, 10 MUL, 11 reserved.
- req_a  in  16*NREQ  operand A per requester, slice i = [16i+15:16i].
- req_b  in  16*NREQ  operand B per requester, slice i = [16i+15:16i].
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_data  out  16  ALU result, low 16 bits.
- resp_err  out  1  set when op was 11 (reserved); resp_data is 0 in that case.
- alu_data1  out  16  to ALU data1.
- alu_data2  out  16  to ALU data2.
- alu_sel  out  2  to ALU sel.
- alu_result  in  16  from ALU result.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, resp_valid, resp_id, resp_data, resp_err, alu_data1/2, alu_sel).
- A reset mid-operation discards the in-flight op. No response is produced. A requester still holding req_valid is re-arbitrated after reset.
- State IDLE:
  - req_ready is combinational: grant is one-hot for the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  - On the edge with req_valid[g] & req_ready[g]: capture op/a/b/g into operand registers, load cycle counter (MUL_CYCLES-1 for MUL, else 0), go to EXEC.
  - No valid requests: stay in IDLE; req_ready=0.
- State EXEC:
  - alu_data1/alu_data2/alu_sel are driven from the operand registers, stable for the whole state. In IDLE and RESP they hold their last values; after reset they are 0.
  - req_ready=0.
  - When the counter is 0: register resp_data=alu_result (0 if op=11), resp_err=(op==11), resp_id=g, go to RESP. Otherwise decrement the counter.
- State RESP:
  - resp_valid=1; resp_id/resp_data/resp_err are stable until the handshake.
  - On resp_valid & resp_ready: rr_ptr=(g+1) mod NREQ, go to IDLE.
  - Back-pressure of any length is legal.
- Latency from the accept edge to resp_valid high: 2 cycles for SUM/SUB/reserved, 1+MUL_CYCLES cycles for MUL.
- Minimum issue interval is 3 cycles: a response handshake and a new accept never share a cycle, because accept only happens in IDLE.
- Requesters must hold req_valid and their operands until accepted. Dropping req_valid before accept is legal; that request is simply not served.
- Arithmetic is modulo 2^16: SUB wraps (0-1=FFFF), MUL keeps the low 16 bits. No carry or overflow flag.
- X on req_op/req_a/req_b of non-granted requesters must not propagate into state.

Decomposition:
- Package alu_pkg:
  - op codes OP_SUM=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_RSV=2'b11 (shared with the ALU);
  - state encoding ST_IDLE/ST_EXEC/ST_RESP;
  - data width constant DW=16.
- Sub-module rr_arbiter, combinational: inputs req[NREQ] and ptr; outputs one-hot gnt and encoded gnt_id. Reused by later shared-resource blocks.
- The ALU instance lives in the parent; this block only drives its ports.

Test Plan:
- Reset mid-MUL: accept MUL with MUL_CYCLES=3, assert rst_n=0 in the 2nd EXEC cycle -> all outputs 0 immediately; no resp_valid after release; req_valid still high -> re-accepted 1 cycle after release.
- Single SUM: req0 a=0x0005 b=0x0003 op=00 -> req_ready[0] high 1 cycle; resp_valid 2 cycles after accept; resp_data=0x0008, resp_id=0, resp_err=0.
- Wrap/width: req1 SUB a=0x0000 b=0x0001 -> resp_data=0xFFFF. MUL a=0x0100 b=0x0100 with MUL_CYCLES=2 -> resp_data=0x0000, resp_valid 3 cycles after accept.
- Round-robin: req0 and req1 both valid continuously with ops 00/01 -> accepts alternate 0,1,0,1. Each response carries the matching resp_id and result. Accepts are spaced 3 cycles apart.
- Back-pressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_data/resp_id stable; req_ready stays 0; release -> IDLE next cycle, then next accept.
- Reserved op: op=11 a=0x1234 b=0x0001 -> resp_data=0x0000, resp_err=1, latency 2.
